// File: rtl/des_pkg.sv
// des_pkg: DES permutation and S-box tables, key-rotation schedule, controller state type
package des_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} des_state_t;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
        8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Index 0 is unused so the table reads 1-indexed by round number
    localparam int SHIFT [17] = '{0, 1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [3:0] SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    // Tables number bits 1..N from the MSB, hence the N-index mapping below
    function automatic logic [63:0] ip_f(input logic [63:0] x);
        for (int i = 0; i < 64; i++) ip_f[63-i] = x[64-IP_T[i]];
    endfunction

    function automatic logic [63:0] fp_f(input logic [63:0] x);
        for (int i = 0; i < 64; i++) fp_f[63-i] = x[64-FP_T[i]];
    endfunction

    function automatic logic [55:0] pc1_f(input logic [63:0] x);
        for (int i = 0; i < 56; i++) pc1_f[55-i] = x[64-PC1_T[i]];
    endfunction

    function automatic logic [47:0] pc2_f(input logic [55:0] x);
        for (int i = 0; i < 48; i++) pc2_f[47-i] = x[56-PC2_T[i]];
    endfunction

    function automatic logic [47:0] e_f(input logic [31:0] x);
        for (int i = 0; i < 48; i++) e_f[47-i] = x[32-E_T[i]];
    endfunction

    function automatic logic [31:0] p_f(input logic [31:0] x);
        for (int i = 0; i < 32; i++) p_f[31-i] = x[32-P_T[i]];
    endfunction

    // Outer bits of each 6-bit group pick the row, inner four the column
    function automatic logic [31:0] sbox_f(input logic [47:0] x);
        logic [5:0] b;
        for (int i = 0; i < 8; i++) begin
            b = x[47-6*i -: 6];
            sbox_f[31-4*i -: 4] = SBOX[i][{b[5], b[0], b[4:1]}];
        end
    endfunction

    function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
        return p_f(sbox_f(e_f(r) ^ k));
    endfunction

    function automatic logic [27:0] rol28(input logic [27:0] x, input int n);
        return n == 1 ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] x, input int n);
        return n == 1 ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    function automatic logic parity_ok_f(input logic [63:0] x);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) ok = ok & (^x[8*i +: 8]);
        return ok;
    endfunction

endpackage

// File: rtl/des_round.sv
// des_round: one combinational DES Feistel round on {L,R} with a 48-bit subkey
module des_round
    import des_pkg::*;
(
    input  logic [63:0] lr,
    input  logic [47:0] sk,
    output logic [63:0] lr_n
);

    assign lr_n = {lr[31:0], lr[63:32] ^ f_func(lr[31:0], sk)};

endmodule

// File: rtl/des_iter_ctrl.sv
// des_iter_ctrl: iterative DES controller, RPC rounds per clock; DES_KEY_PARITY_EN enables key parity rejection
module des_iter_ctrl
    import des_pkg::*;
#(
    parameter int RPC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        in_ready,
    input  logic        e,
    input  logic [63:0] k,
    input  logic [63:0] in,
    output logic [63:0] out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic [4:0]  round,
    output logic        err
);

    if (!(RPC == 1 || RPC == 2 || RPC == 4)) begin : g_bad_rpc
        $error("des_iter_ctrl: RPC must be 1, 2 or 4");
    end

    des_state_t  state;
    logic [63:0] lr_q;
    logic [27:0] c;
    logic [27:0] d;
    logic        mode;
    logic [4:0]  rnd;
    logic [63:0] out_q;
    logic        accept;
    logic        key_ok;
    logic [63:0] lr_c [RPC+1];
    logic [27:0] c_c [RPC+1];
    logic [27:0] d_c [RPC+1];

    assign in_ready  = state == IDLE || (state == DONE && out_ready);
    assign accept    = start && in_ready;
    assign busy      = state == RUN;
    assign out_valid = state == DONE;
    assign round     = rnd;
    assign out       = out_q;

    assign lr_c[0] = lr_q;
    assign c_c[0]  = c;
    assign d_c[0]  = d;

    // Encrypt rotates left before using the key; decrypt uses the key then rotates right
    for (genvar j = 0; j < RPC; j++) begin : g_rnd
        logic [4:0]  rn;
        logic [27:0] ce;
        logic [27:0] de;
        logic [47:0] sk;
        assign rn         = rnd + 5'(j + 1);
        assign ce         = rol28(c_c[j], SHIFT[rn]);
        assign de         = rol28(d_c[j], SHIFT[rn]);
        assign sk         = mode ? pc2_f({ce, de}) : pc2_f({c_c[j], d_c[j]});
        assign c_c[j+1]   = mode ? ce : ror28(c_c[j], SHIFT[17-rn]);
        assign d_c[j+1]   = mode ? de : ror28(d_c[j], SHIFT[17-rn]);
        des_round u_round (.lr(lr_c[j]), .sk(sk), .lr_n(lr_c[j+1]));
    end

`ifdef DES_KEY_PARITY_EN
    logic err_q;
    assign key_ok = parity_ok_f(k);
    assign err    = err_q;
    // One-cycle flag for a start refused because of a bad key byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else
            err_q <= accept && !key_ok;
    end
`else
    assign key_ok = 1'b1;
    assign err    = 1'b0;
`endif

    // Sequencing: load at accept, RPC rounds per RUN cycle, hold result in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            lr_q  <= '0;
            c     <= '0;
            d     <= '0;
            mode  <= 1'b0;
            rnd   <= '0;
            out_q <= '0;
        end else if (accept && key_ok) begin
            state      <= RUN;
            lr_q       <= ip_f(in);
            {c, d}     <= pc1_f(k);
            mode       <= e;
            rnd        <= '0;
        end else if (accept) begin
            state <= IDLE;
        end else if (state == RUN) begin
            lr_q <= lr_c[RPC];
            c    <= c_c[RPC];
            d    <= d_c[RPC];
            rnd  <= rnd + 5'(RPC);
            if (rnd + 5'(RPC) == 5'd16) begin
                state <= DONE;
                out_q <= fp_f({lr_c[RPC][31:0], lr_c[RPC][63:32]});
            end
        end else if (state == DONE && out_ready) begin
            state <= IDLE;
        end
    end

endmodule
